// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory req/ack port plus the decode-side valid/ready port.
// Latency: n/a (wires only).
// Backpressure: imem_req holds until imem_ack; instr_valid holds until instr_ready.
// Ports (master = fetch unit, slave = environment):
//   pc_next, imem_ack, imem_rdata, instr_ready          -> into fetch unit
//   imem_req, imem_addr, instr_valid, pc, instr, fields, fetch_err -> out of fetch unit
interface instr_fetch_unit_if;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [25:0] jtarget;
    logic        fetch_err;

    modport master (
        input  pc_next, imem_ack, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, pc, instr,
               opcode, rs, rt, rd, shamt, funct, imm_sext, jtarget, fetch_err
    );

    modport slave (
        output pc_next, imem_ack, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, pc, instr,
               opcode, rs, rt, rd, shamt, funct, imm_sext, jtarget, fetch_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage: owns the PC, reads imem via req/ack, holds the word for decode.
// Latency: zero-wait memory gives instr_valid one cycle after the request; 2 cycles/instr min.
// Backpressure: instruction, PC and decoded fields stay frozen while instr_ready is low.
// Ports: clk, reset (synchronous, active-low), bus (instr_fetch_unit_if.master).
// Optional: define FETCH_TIMEOUT_EN to raise fetch_err after TIMEOUT FETCH cycles with no ack.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    instr_fetch_unit_if.master bus
);

    // Catch bad configurations at elaboration rather than as odd runtime behaviour.
    if (RESET_PC[1:0] != 2'b00 || TIMEOUT < 1 || TIMEOUT > 65536) begin : g_bad_param
        $error("instr_fetch_unit: RESET_PC must be word aligned and TIMEOUT in 1..65536");
    end

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        err_q;
    logic        pc_next_aligned;
    logic        timed_out;

    assign pc_next_aligned = (bus.pc_next[1:0] == 2'b00);

`ifdef FETCH_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // An ack on the limit cycle takes priority, so the timeout only fires without ack.
    assign timed_out = (state == S_FETCH) && !bus.imem_ack &&
                       (wait_cnt == 16'(TIMEOUT - 1));

    // Counter is zero on every entry to FETCH because it is held clear elsewhere.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == S_FETCH && !bus.imem_ack) begin
            wait_cnt <= wait_cnt + 16'd1;
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH: begin
                if (bus.imem_ack) begin
                    state_nx = S_HOLD;
                end else if (timed_out) begin
                    state_nx = S_ERR;
                end
            end
            S_HOLD: begin
                if (bus.instr_ready) begin
                    state_nx = pc_next_aligned ? S_FETCH : S_ERR;
                end
            end
            S_ERR:   state_nx = S_ERR;
            default: state_nx = S_FETCH;
        endcase
    end

    // Output logic; reset gating keeps both handshakes quiet while reset is held.
    always_comb begin
        bus.imem_req    = 1'b0;
        bus.instr_valid = 1'b0;
        case (state)
            S_FETCH: bus.imem_req    = reset;
            S_HOLD:  bus.instr_valid = reset;
            default: ;
        endcase
    end

    // Datapath: PC, captured instruction, sticky error
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == S_FETCH && bus.imem_ack) begin
                instr_q <= bus.imem_rdata;
            end
            // pc_next is only looked at on the HOLD handoff edge.
            if (state == S_HOLD && bus.instr_ready && pc_next_aligned) begin
                pc_q <= bus.pc_next;
            end
            // ERR is absorbing until reset, so this also keeps the flag sticky.
            if (state_nx == S_ERR) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.instr     = instr_q;
    assign bus.fetch_err = err_q;
    assign bus.opcode    = instr_q[31:26];
    assign bus.rs        = instr_q[25:21];
    assign bus.rt        = instr_q[20:16];
    assign bus.rd        = instr_q[15:11];
    assign bus.shamt     = instr_q[10:6];
    assign bus.funct     = instr_q[5:0];
    assign bus.imm_sext  = {{16{instr_q[15]}}, instr_q[15:0]};
    assign bus.jtarget   = instr_q[25:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table plus hand sequences for reset and timeout.
// Latency: n/a.
// Backpressure: exercised through instr_ready stalls in the table.
module tb_instr_fetch_unit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic [31:0] pcn;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_vld;
        logic [31:0] e_instr;
        logic        e_err;
        logic [5:0]  e_op;
        logic [31:0] e_imm;
        logic [25:0] e_jt;
    } vec_t;

    vec_t vt[22];

    function automatic vec_t mk(logic rst, logic ack, logic [31:0] rdata, logic rdy,
                                logic [31:0] pcn, logic e_req, logic [31:0] e_pc,
                                logic e_vld, logic [31:0] e_instr, logic e_err,
                                logic [5:0] e_op, logic [31:0] e_imm, logic [25:0] e_jt);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.pcn = pcn;
        v.e_req = e_req; v.e_pc = e_pc; v.e_vld = e_vld; v.e_instr = e_instr;
        v.e_err = e_err; v.e_op = e_op; v.e_imm = e_imm; v.e_jt = e_jt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic ack, input logic [31:0] rdata,
                         input logic rdy, input logic [31:0] pcn);
        reset           = rst;
        bus.imem_ack    = ack;
        bus.imem_rdata  = rdata;
        bus.instr_ready = rdy;
        bus.pc_next     = pcn;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        string tag;
        checks = 0;
        errors = 0;

        // inputs: rst ack rdata rdy pc_next | expected: req pc vld instr err opcode imm_sext jtarget
        vt[0]  = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 6'h00, 32'h0,         26'h0);
        // zero-wait fetch of addi
        vt[1]  = mk(1, 1, 32'h2010_0005, 0, 32'h0,         1, 32'h0,         0, 32'h0,         0, 6'h00, 32'h0,         26'h0);
        // hold four cycles with decode stalled; stray ack must not overwrite
        vt[2]  = mk(1, 1, 32'hDEAD_BEEF, 0, 32'h8,         0, 32'h0,         1, 32'h2010_0005, 0, 6'h08, 32'h5,         26'h010_0005);
        vt[3]  = mk(1, 0, 32'h0,         0, 32'h8,         0, 32'h0,         1, 32'h2010_0005, 0, 6'h08, 32'h5,         26'h010_0005);
        vt[4]  = mk(1, 0, 32'h0,         0, 32'h8,         0, 32'h0,         1, 32'h2010_0005, 0, 6'h08, 32'h5,         26'h010_0005);
        vt[5]  = mk(1, 0, 32'h0,         0, 32'h8,         0, 32'h0,         1, 32'h2010_0005, 0, 6'h08, 32'h5,         26'h010_0005);
        vt[6]  = mk(1, 0, 32'h0,         1, 32'h8,         0, 32'h0,         1, 32'h2010_0005, 0, 6'h08, 32'h5,         26'h010_0005);
        // three wait cycles then ack with negative immediate
        vt[7]  = mk(1, 0, 32'h0,         0, 32'h0,         1, 32'h8,         0, 32'h2010_0005, 0, 6'h08, 32'h5,         26'h010_0005);
        vt[8]  = mk(1, 0, 32'h0,         0, 32'h0,         1, 32'h8,         0, 32'h2010_0005, 0, 6'h08, 32'h5,         26'h010_0005);
        vt[9]  = mk(1, 0, 32'h0,         0, 32'h0,         1, 32'h8,         0, 32'h2010_0005, 0, 6'h08, 32'h5,         26'h010_0005);
        vt[10] = mk(1, 1, 32'h2000_FFFF, 0, 32'h0,         1, 32'h8,         0, 32'h2010_0005, 0, 6'h08, 32'h5,         26'h010_0005);
        vt[11] = mk(1, 0, 32'h0,         1, 32'hC,         0, 32'h8,         1, 32'h2000_FFFF, 0, 6'h08, 32'hFFFF_FFFF, 26'h000_FFFF);
        // jump word, then misaligned handoff
        vt[12] = mk(1, 1, 32'h0800_0010, 0, 32'h0,         1, 32'hC,         0, 32'h2000_FFFF, 0, 6'h08, 32'hFFFF_FFFF, 26'h000_FFFF);
        vt[13] = mk(1, 0, 32'h0,         1, 32'h6,         0, 32'hC,         1, 32'h0800_0010, 0, 6'h02, 32'h10,        26'h10);
        vt[14] = mk(1, 1, 32'h5555_5555, 1, 32'h10,        0, 32'hC,         0, 32'h0800_0010, 1, 6'h02, 32'h10,        26'h10);
        vt[15] = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'hC,         0, 32'h0800_0010, 1, 6'h02, 32'h10,        26'h10);
        vt[16] = mk(1, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 32'h0,         0, 6'h00, 32'h0,         26'h0);
        // reset coinciding with ack: data discarded
        vt[17] = mk(0, 1, 32'h1234_5678, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 6'h00, 32'h0,         26'h0);
        vt[18] = mk(1, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 32'h0,         0, 6'h00, 32'h0,         26'h0);
        // PC wrap target is legal
        vt[19] = mk(1, 1, 32'h0000_0020, 0, 32'h0,         1, 32'h0,         0, 32'h0,         0, 6'h00, 32'h0,         26'h0);
        vt[20] = mk(1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         1, 32'h0000_0020, 0, 6'h00, 32'h20,        26'h20);
        vt[21] = mk(1, 0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0000_0020, 0, 6'h00, 32'h20,        26'h20);

        drive(0, 0, 32'h0, 0, 32'h0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(vt[i].rst, vt[i].ack, vt[i].rdata, vt[i].rdy, vt[i].pcn);
            #1;
            tag = $sformatf("v%0d", i);
            chk({tag, " imem_req"},    32'(bus.imem_req),    32'(vt[i].e_req));
            chk({tag, " imem_addr"},   bus.imem_addr,        vt[i].e_pc);
            chk({tag, " pc"},          bus.pc,               vt[i].e_pc);
            chk({tag, " instr_valid"}, 32'(bus.instr_valid), 32'(vt[i].e_vld));
            chk({tag, " instr"},       bus.instr,            vt[i].e_instr);
            chk({tag, " fetch_err"},   32'(bus.fetch_err),   32'(vt[i].e_err));
            chk({tag, " opcode"},      32'(bus.opcode),      32'(vt[i].e_op));
            chk({tag, " imm_sext"},    bus.imm_sext,         vt[i].e_imm);
            chk({tag, " jtarget"},     32'(bus.jtarget),     32'(vt[i].e_jt));
            if (i == 2) begin
                chk("v2 rt", 32'(bus.rt), 32'd16);
                chk("v2 rs", 32'(bus.rs), 32'd0);
            end
            if (i == 21) begin
                chk("v21 funct", 32'(bus.funct), 32'h20);
                chk("v21 rd",    32'(bus.rd),    32'd0);
                chk("v21 shamt", 32'(bus.shamt), 32'd0);
            end
        end

        // Reset arriving in the middle of HOLD
        @(negedge clk);
        drive(1, 1, 32'h1111_1111, 0, 32'h0);
        @(negedge clk);
        drive(1, 0, 32'h0, 0, 32'h0);
        #1;
        chk("hold instr_valid", 32'(bus.instr_valid), 32'd1);
        chk("hold instr",       bus.instr,            32'h1111_1111);
        @(negedge clk);
        drive(0, 0, 32'h0, 1, 32'h40);
        #1;
        chk("rst-hold instr_valid gated", 32'(bus.instr_valid), 32'd0);
        chk("rst-hold imem_req gated",    32'(bus.imem_req),    32'd0);
        @(negedge clk);
        drive(1, 0, 32'h0, 0, 32'h0);
        #1;
        chk("post-rst pc",          bus.pc,               32'h0);
        chk("post-rst instr",       bus.instr,            32'h0);
        chk("post-rst instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("post-rst imem_req",    32'(bus.imem_req),    32'd1);

`ifdef FETCH_TIMEOUT_EN
        // No ack for 16 FETCH cycles -> error
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("to c%0d imem_req", c),  32'(bus.imem_req),  32'd1);
            chk($sformatf("to c%0d fetch_err", c), 32'(bus.fetch_err), 32'd0);
            @(negedge clk);
            drive(1, 0, 32'h0, 0, 32'h0);
            #1;
        end
        chk("timeout fetch_err", 32'(bus.fetch_err), 32'd1);
        chk("timeout imem_req",  32'(bus.imem_req),  32'd0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 32'h0);
        @(negedge clk);
        drive(1, 0, 32'h0, 0, 32'h0);
        #1;
        chk("to-rst fetch_err", 32'(bus.fetch_err), 32'd0);
        // Ack on the 16th cycle beats the limit
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            drive(1, 0, 32'h0, 0, 32'h0);
        end
        @(negedge clk);
        drive(1, 1, 32'hABCD_0000, 0, 32'h0);
        @(negedge clk);
        drive(1, 0, 32'h0, 0, 32'h0);
        #1;
        chk("late-ack fetch_err",   32'(bus.fetch_err),   32'd0);
        chk("late-ack instr_valid", 32'(bus.instr_valid), 32'd1);
        chk("late-ack instr",       bus.instr,            32'hABCD_0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
